// File: rtl/mdio_seq_engine.sv
// MDIO management sequencer: runs a microprogram from an external combinational ROM
// and turns each instruction into cmd_valid/cmd_ready transactions for the MDIO master.
//   IDLE     | waiting for start
//   FETCH    | latch instruction at pc and dispatch by opcode
//   ISSUE    | present one command; wait for the master to accept it
//   COMPLETE | wait for the master to finish; capture read data and decide
//   WAITING  | timed delay of data*WAIT_UNIT clocks
//   ERR      | record the fault, then return to IDLE
module mdio_seq_engine #(
  parameter int PROG_AW     = 5,
  parameter int WAIT_UNIT   = 65536,
  parameter int POLL_MAX    = 1024,
  parameter int CMD_TIMEOUT = 1048576
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  output logic [PROG_AW-1:0] prog_addr,
  input  logic [39:0]        prog_data,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [1:0]         err_code,
  output logic [PROG_AW-1:0] err_pc,
  output logic [15:0]        last_read,
  output logic               cmd_valid,
  input  logic               cmd_ready,
  output logic               read_write,
  output logic [4:0]         reg_adr,
  output logic [15:0]        write_data,
  input  logic               read_data_valid,
  input  logic [15:0]        read_data
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ISSUE, S_COMPLETE, S_WAITING, S_ERR
  } state_t;

  localparam logic [2:0] OP_END   = 3'd0;
  localparam logic [2:0] OP_WRITE = 3'd1;
  localparam logic [2:0] OP_READ  = 3'd2;
  localparam logic [2:0] OP_RMW   = 3'd3;
  localparam logic [2:0] OP_POLL  = 3'd4;
  localparam logic [2:0] OP_WAIT  = 3'd5;
  localparam logic [2:0] OP_JUMP  = 3'd6;

  state_t             state_q, state_d;
  logic [PROG_AW-1:0] pc_q, pc_d;
  logic [2:0]         op_q, op_d;
  logic [4:0]         reg_q, reg_d;
  logic [15:0]        data_q, data_d;
  logic [15:0]        mask_q, mask_d;
  logic               phase_q, phase_d;
  logic               got_rd_q, got_rd_d;
  logic               issued_q, issued_d;
  logic [31:0]        poll_cnt_q, poll_cnt_d;
  logic [31:0]        tmo_cnt_q, tmo_cnt_d;
  logic [31:0]        wait_cnt_q, wait_cnt_d;
  logic [15:0]        last_read_q, last_read_d;
  logic               error_q, error_d;
  logic [1:0]         err_code_q, err_code_d;
  logic [PROG_AW-1:0] err_pc_q, err_pc_d;
  logic               done_q, done_d;

  logic               is_read;
  logic [15:0]        rd_val;
  logic               have_rd;
  logic               poll_hit;
  logic [31:0]        wait_tgt;
  logic               fault;
  logic [1:0]         fault_code;

  // RMW phase 0 is the read half; phase 1 writes back the merged value.
  assign is_read  = (op_q == OP_READ) || (op_q == OP_POLL) || ((op_q == OP_RMW) && !phase_q);
  assign rd_val   = read_data_valid ? read_data : last_read_q;
  assign have_rd  = got_rd_q | read_data_valid;
  assign poll_hit = ((rd_val & mask_q) == (data_q & mask_q));
  assign wait_tgt = {16'd0, data_q} * 32'(WAIT_UNIT);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    op_d        = op_q;
    reg_d       = reg_q;
    data_d      = data_q;
    mask_d      = mask_q;
    phase_d     = phase_q;
    got_rd_d    = got_rd_q;
    issued_d    = issued_q;
    poll_cnt_d  = poll_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    last_read_d = last_read_q;
    error_d     = error_q;
    err_code_d  = err_code_q;
    err_pc_d    = err_pc_q;
    done_d      = 1'b0;
    fault       = 1'b0;
    fault_code  = 2'd0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          error_d    = 1'b0;
          err_code_d = 2'd0;
          err_pc_d   = '0;
          pc_d       = '0;
          state_d    = S_FETCH;
        end
      end
      S_FETCH: begin
        op_d       = prog_data[39:37];
        reg_d      = prog_data[36:32];
        data_d     = prog_data[31:16];
        mask_d     = prog_data[15:0];
        phase_d    = 1'b0;
        got_rd_d   = 1'b0;
        issued_d   = 1'b0;
        poll_cnt_d = '0;
        tmo_cnt_d  = '0;
        wait_cnt_d = '0;
        case (prog_data[39:37])
          OP_END: begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
          OP_WRITE, OP_READ, OP_RMW, OP_POLL: state_d = S_ISSUE;
          OP_WAIT: begin
            if (prog_data[31:16] == 16'd0) pc_d = pc_q + PROG_AW'(1);
            else                           state_d = S_WAITING;
          end
          OP_JUMP: pc_d = prog_data[16 +: PROG_AW];
          default: begin
            fault      = 1'b1;
            fault_code = 2'd3;
          end
        endcase
      end
      S_ISSUE: begin
        tmo_cnt_d = tmo_cnt_q + 32'd1;
        if (!issued_q) begin
          if (cmd_ready) issued_d = 1'b1;
        end else if (!cmd_ready) begin
          issued_d = 1'b0;
          state_d  = S_COMPLETE;
        end
      end
      S_COMPLETE: begin
        tmo_cnt_d = tmo_cnt_q + 32'd1;
        if (read_data_valid) begin
          last_read_d = read_data;
          got_rd_d    = 1'b1;
        end
        if (cmd_ready) begin
          if (is_read && !have_rd) begin
            fault      = 1'b1;
            fault_code = 2'd3;
          end else if ((op_q == OP_RMW) && !phase_q) begin
            phase_d   = 1'b1;
            got_rd_d  = 1'b0;
            tmo_cnt_d = '0;
            state_d   = S_ISSUE;
          end else if ((op_q == OP_POLL) && !poll_hit) begin
            if (poll_cnt_q == 32'(POLL_MAX - 1)) begin
              fault      = 1'b1;
              fault_code = 2'd1;
            end else begin
              poll_cnt_d = poll_cnt_q + 32'd1;
              got_rd_d   = 1'b0;
              tmo_cnt_d  = '0;
              state_d    = S_ISSUE;
            end
          end else begin
            pc_d    = pc_q + PROG_AW'(1);
            state_d = S_FETCH;
          end
        end
      end
      S_WAITING: begin
        wait_cnt_d = wait_cnt_q + 32'd1;
        if (wait_cnt_q == wait_tgt - 32'd1) begin
          pc_d    = pc_q + PROG_AW'(1);
          state_d = S_FETCH;
        end
      end
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A hung transaction overrides whatever the handshake logic decided this cycle.
    if (((state_q == S_ISSUE) || (state_q == S_COMPLETE)) &&
        (tmo_cnt_q == 32'(CMD_TIMEOUT - 1))) begin
      fault      = 1'b1;
      fault_code = 2'd2;
    end

    if (fault) begin
      state_d    = S_ERR;
      issued_d   = 1'b0;
      error_d    = 1'b1;
      err_code_d = fault_code;
      err_pc_d   = pc_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      op_q        <= '0;
      reg_q       <= '0;
      data_q      <= '0;
      mask_q      <= '0;
      phase_q     <= 1'b0;
      got_rd_q    <= 1'b0;
      issued_q    <= 1'b0;
      poll_cnt_q  <= '0;
      tmo_cnt_q   <= '0;
      wait_cnt_q  <= '0;
      last_read_q <= '0;
      error_q     <= 1'b0;
      err_code_q  <= '0;
      err_pc_q    <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      op_q        <= op_d;
      reg_q       <= reg_d;
      data_q      <= data_d;
      mask_q      <= mask_d;
      phase_q     <= phase_d;
      got_rd_q    <= got_rd_d;
      issued_q    <= issued_d;
      poll_cnt_q  <= poll_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      last_read_q <= last_read_d;
      error_q     <= error_d;
      err_code_q  <= err_code_d;
      err_pc_q    <= err_pc_d;
      done_q      <= done_d;
    end
  end

  // cmd_valid is decoded from state so it falls with reset, not on the next edge.
  assign cmd_valid  = (state_q == S_ISSUE) && issued_q;
  assign read_write = is_read;
  assign reg_adr    = reg_q;
  assign write_data = (op_q == OP_RMW) ? ((last_read_q & ~mask_q) | (data_q & mask_q)) : data_q;
  assign prog_addr  = pc_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign error      = error_q;
  assign err_code   = err_code_q;
  assign err_pc     = err_pc_q;
  assign last_read  = last_read_q;

endmodule

// File: tb/tb_mdio_seq_engine.sv
// Bench for mdio_seq_engine: directed bring-up programs plus random programs,
// checked against a program interpreter with a simple PHY register model.
module tb_mdio_seq_engine;
  localparam int AW = 5;
  localparam int WU = 8;
  localparam int PM = 4;
  localparam int CT = 100;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] prog_addr;
  logic [39:0]   prog_data;
  logic          busy, done, error;
  logic [1:0]    err_code;
  logic [AW-1:0] err_pc;
  logic [15:0]   last_read;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          read_write;
  logic [4:0]    reg_adr;
  logic [15:0]   write_data;
  logic          read_data_valid;
  logic [15:0]   read_data;

  logic [39:0]   rom [32];
  assign prog_data = rom[prog_addr];

  mdio_seq_engine #(.PROG_AW(AW), .WAIT_UNIT(WU), .POLL_MAX(PM), .CMD_TIMEOUT(CT)) dut (
    .clk(clk), .resetn(resetn), .start(start),
    .prog_addr(prog_addr), .prog_data(prog_data),
    .busy(busy), .done(done), .error(error), .err_code(err_code), .err_pc(err_pc),
    .last_read(last_read),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .read_write(read_write),
    .reg_adr(reg_adr), .write_data(write_data),
    .read_data_valid(read_data_valid), .read_data(read_data)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) if (done) done_cnt++;

  // MDIO master / PHY model driving the handshake
  logic [15:0] phy_tb [32];
  logic [15:0] resp_tb [$];
  logic [21:0] log_q [$];
  bit hang = 0, nodata = 0, rnd_timing = 0;
  int fix_acc = 2, fix_lat = 40;

  initial begin : responder
    logic        rw;
    logic [4:0]  r;
    logic [15:0] wd, val;
    int          acc, lat;
    cmd_ready = 1'b1; read_data_valid = 1'b0; read_data = '0;
    forever begin
      @(posedge clk); #1;
      if (cmd_valid) begin
        rw = read_write; r = reg_adr; wd = write_data;
        log_q.push_back({rw, r, rw ? 16'h0 : wd});
        acc = rnd_timing ? int'($urandom_range(0, 2)) : fix_acc;
        lat = rnd_timing ? int'($urandom_range(0, 6)) : fix_lat;
        for (int i = 0; i < acc; i++) begin @(posedge clk); #1; end
        cmd_ready = 1'b0;
        @(posedge clk); #1;
        while (hang) begin @(posedge clk); #1; end
        for (int i = 0; i < lat; i++) begin @(posedge clk); #1; end
        if (!rw) phy_tb[r] = wd;
        if (rw && !nodata) begin
          if (resp_tb.size() > 0) val = resp_tb.pop_front();
          else                    val = phy_tb[r];
          read_data = val; read_data_valid = 1'b1;
          if (rnd_timing && ($urandom_range(0, 1) == 1)) begin
            cmd_ready = 1'b1;
            @(posedge clk); #1;
            read_data_valid = 1'b0;
          end else begin
            @(posedge clk); #1;
            read_data_valid = 1'b0;
            cmd_ready = 1'b1;
          end
        end else begin
          cmd_ready = 1'b1;
        end
      end
    end
  end

  // Reference interpreter: executes the program at instruction level
  logic [15:0] phy_m [32];
  logic [15:0] resp_m [$];
  logic [21:0] exp_q [$];
  logic [15:0] last_m = '0;
  bit e_done, e_err;
  int e_code, e_pc;

  task automatic m_read(input logic [4:0] r, output logic [15:0] v);
    if (resp_m.size() > 0) v = resp_m.pop_front();
    else                   v = phy_m[r];
  endtask

  task automatic model_run(input bit nd);
    int pc, op;
    logic [39:0] w;
    logic [4:0] r;
    logic [15:0] d, m, v;
    bit hit;
    exp_q.delete(); e_done = 0; e_err = 0; e_code = 0; e_pc = 0; pc = 0;
    for (int step = 0; step < 200; step++) begin
      w = rom[pc]; op = int'(w[39:37]); r = w[36:32]; d = w[31:16]; m = w[15:0];
      if (op == 0) begin e_done = 1; return; end
      if (op == 7) begin e_err = 1; e_code = 3; e_pc = pc; return; end
      if (op == 1) begin exp_q.push_back({1'b0, r, d}); phy_m[r] = d; end
      if (op == 2 || op == 3) begin
        exp_q.push_back({1'b1, r, 16'h0});
        if (nd) begin e_err = 1; e_code = 3; e_pc = pc; return; end
        m_read(r, v); last_m = v;
        if (op == 3) begin
          v = (v & ~m) | (d & m);
          exp_q.push_back({1'b0, r, v}); phy_m[r] = v;
        end
      end
      if (op == 4) begin
        hit = 0;
        for (int t = 0; t < PM && !hit; t++) begin
          exp_q.push_back({1'b1, r, 16'h0});
          if (nd) begin e_err = 1; e_code = 3; e_pc = pc; return; end
          m_read(r, v); last_m = v;
          hit = ((v & m) == (d & m));
        end
        if (!hit) begin e_err = 1; e_code = 1; e_pc = pc; return; end
      end
      if (op == 6) pc = int'(d) % 32;
      else         pc = (pc + 1) % 32;
    end
  endtask

  function automatic logic [39:0] ins(input int op, input int r, input int d, input int m);
    return {op[2:0], r[4:0], d[15:0], m[15:0]};
  endfunction

  task automatic clear_env();
    for (int a = 0; a < 32; a++) rom[a] = '0;
    resp_tb.delete(); resp_m.delete();
  endtask

  task automatic set_phy(input int r, input logic [15:0] v);
    phy_tb[r] = v; phy_m[r] = v;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic run_and_check(input string name, input bit nd);
    int cyc, d0, n;
    model_run(nd);
    log_q.delete();
    nodata = nd;
    d0 = done_cnt;
    pulse_start();
    cyc = 0;
    while (busy && cyc < 5000) begin @(negedge clk); cyc++; end
    check_val({name, " finish"}, 32'(cyc < 5000), 1);
    @(negedge clk);
    nodata = 0;
    check_val({name, " ncmd"}, log_q.size(), exp_q.size());
    n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check_val($sformatf("%s cmd%0d", name, i), log_q[i], exp_q[i]);
    check_val({name, " done"}, done_cnt - d0, e_done);
    check_val({name, " error"}, error, e_err);
    check_val({name, " code"}, err_code, e_code);
    if (e_err) check_val({name, " err_pc"}, err_pc, e_pc);
    check_val({name, " last_read"}, last_read, last_m);
    check_val({name, " busy"}, busy, 0);
  endtask

  initial begin : main
    int cyc, d0, n, op, r;
    logic [15:0] v, dd, mm;

    for (int a = 0; a < 32; a++) set_phy(a, '0);
    clear_env();
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst busy", busy, 0);
    check_val("rst done", done, 0);
    check_val("rst error", error, 0);
    check_val("rst err_code", err_code, 0);
    check_val("rst cmd_valid", cmd_valid, 0);
    check_val("rst prog_addr", prog_addr, 0);
    check_val("rst last_read", last_read, 0);
    check_val("rst outs", {read_write, reg_adr, write_data, err_pc}, 0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // single write, slow master
    clear_env();
    rom[0] = ins(1, 0, 16'h8000, 0);
    run_and_check("write", 0);

    fix_acc = 1; fix_lat = 3;
    // read-modify-write
    clear_env();
    set_phy(5'h11, 16'h0042);
    rom[0] = ins(3, 5'h11, 16'h0100, 16'h0100);
    run_and_check("rmw", 0);
    if (log_q.size() > 1) check_val("rmw wdata", log_q[1], {1'b0, 5'h11, 16'h0142});
    check_val("rmw last", last_read, 16'h0042);

    // poll that succeeds on the third read
    clear_env();
    rom[0] = ins(4, 1, 16'h0024, 16'h0024);
    rom[1] = ins(1, 2, 16'h00AA, 0);
    resp_tb.push_back(16'h0004); resp_tb.push_back(16'h0020); resp_tb.push_back(16'h0024);
    resp_m.push_back(16'h0004);  resp_m.push_back(16'h0020);  resp_m.push_back(16'h0024);
    run_and_check("poll_ok", 0);

    // poll exhausted
    clear_env();
    set_phy(1, 16'h0000);
    rom[0] = ins(1, 2, 16'h1234, 0);
    rom[1] = ins(4, 1, 16'h0024, 16'h0024);
    run_and_check("poll_max", 0);
    check_val("poll_max code", err_code, 1);

    // illegal opcode and missing read data
    clear_env();
    rom[0] = ins(1, 3, 16'h0001, 0);
    rom[1] = ins(7, 0, 0, 0);
    run_and_check("illegal", 0);
    clear_env();
    rom[0] = ins(2, 5, 0, 0);
    run_and_check("nodata", 1);

    // timed wait
    clear_env();
    rom[0] = ins(5, 0, 3, 0);
    d0 = done_cnt;
    pulse_start();
    cyc = 0;
    @(negedge clk);
    while (prog_addr != 1 && cyc < 200) begin @(negedge clk); cyc++; end
    check_val("wait cycles", cyc, 1 + 3 * WU);
    repeat (3) @(negedge clk);
    check_val("wait done", done_cnt - d0, 1);

    // command timeout, then recovery from pc 0
    clear_env();
    rom[0] = ins(1, 3, 16'hABCD, 0);
    fix_acc = 0; fix_lat = 0; hang = 1;
    d0 = done_cnt;
    log_q.delete();
    pulse_start();
    cyc = 0;
    @(negedge clk);
    while (!error && cyc < 500) begin @(negedge clk); cyc++; end
    check_val("tmo cycle", cyc, 1 + CT);
    check_val("tmo code", err_code, 2);
    check_val("tmo err_pc", err_pc, 0);
    check_val("tmo cmd_valid", cmd_valid, 0);
    repeat (3) @(negedge clk);
    check_val("tmo busy", busy, 0);
    check_val("tmo no done", done_cnt - d0, 0);
    hang = 0;
    repeat (5) @(negedge clk);
    phy_m[3] = 16'hABCD;
    clear_env();
    rom[0] = ins(1, 4, 16'h5555, 0);
    run_and_check("rerun", 0);

    // read/jump loop aborted by reset in COMPLETE; start while busy ignored
    clear_env();
    set_phy(1, 16'h1357);
    rom[0] = ins(2, 1, 0, 0);
    rom[1] = ins(6, 0, 0, 0);
    fix_acc = 1; fix_lat = 10;
    log_q.delete();
    pulse_start();
    repeat (30) @(negedge clk);
    start = 1'b1; @(negedge clk); start = 1'b0;
    check_val("loop busy", busy, 1);
    check_val("loop error", error, 0);
    cyc = 0;
    @(negedge clk);
    while (!(cmd_ready == 0 && cmd_valid == 0) && cyc < 200) begin @(negedge clk); cyc++; end
    check_val("loop reach complete", 32'(cyc < 200), 1);
    #2 resetn = 1'b0;
    #1;
    check_val("async busy", busy, 0);
    check_val("async cmd_valid", cmd_valid, 0);
    check_val("async pc", prog_addr, 0);
    n = log_q.size();
    check_val("loop reads", 32'(n >= 2), 1);
    for (int i = 0; i < n; i++) check_val($sformatf("loop cmd%0d", i), log_q[i], {1'b1, 5'd1, 16'h0});
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (30) @(negedge clk);
    // reset while a command is actively presented
    pulse_start();
    cyc = 0;
    while (!cmd_valid && cyc < 50) begin @(negedge clk); cyc++; end
    resetn = 1'b0;
    #1;
    check_val("async cmd_valid2", cmd_valid, 0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (30) @(negedge clk);
    last_m = '0;

    // random programs
    rnd_timing = 1;
    for (int it = 0; it < 40; it++) begin
      clear_env();
      for (int a = 0; a < 32; a++) begin v = 16'($urandom); set_phy(a, v); end
      n = $urandom_range(2, 8);
      for (int k = 0; k < n; k++) begin
        op = $urandom_range(1, 5);
        r  = $urandom_range(0, 31);
        dd = 16'($urandom);
        mm = 16'($urandom);
        if (op == 4 && $urandom_range(0, 1) == 1) dd = phy_m[r];
        if (op == 5) dd = 16'($urandom_range(0, 2));
        rom[k] = ins(op, r, int'(dd), int'(mm));
      end
      run_and_check($sformatf("rnd%0d", it), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
